// File: rtl/if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction-fetch front end feeding the ID stage. Owns the fetch PC,
// issues one word read per cycle to a synchronous instruction BRAM
// (1-cycle read latency), buffers returned {inst, pc} pairs in a small FIFO
// and presents the FIFO head to ID through a valid/ready handshake.
// A redirect flushes everything queued or in flight and restarts fetch.
//
// Optional feature macro: PREFETCH_BYPASS_EN
//   When defined, a response arriving while the FIFO is empty is presented
//   to ID in the same cycle; if ID accepts it, it is never written.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, 2..16)
//   RESET_PC  fetch PC loaded on reset
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   imem_req     read request this cycle
//   imem_addr    word-aligned fetch address
//   imem_rdata   instruction, valid the cycle after imem_req
//   id_valid     head entry available to ID
//   id_ready     ID accepts head this cycle
//   id_inst      head instruction
//   id_pc        head PC
//   id_npc       head PC + 4
//   redirect     flush and restart fetch
//   redirect_pc  restart target (bits [1:0] ignored)
//   occupancy    current FIFO entry count
// ---------------------------------------------------------------------------
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [31:0]              id_inst,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_npc,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   req_pc_q;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];

    logic [CW:0]   credit_used;
    logic          issue;
    logic          fifo_nonempty;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credits cover both stored entries and the response still in flight,
    // so a response always finds a free slot even if ID never pops.
    assign credit_used   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue         = rst_n & ~redirect & (credit_used < DEPTH_C);
    assign fifo_nonempty = (count_q != '0);

`ifdef PREFETCH_BYPASS_EN
    // Empty FIFO with a response arriving: hand it straight to ID.
    assign bypass = ~fifo_nonempty & inflight_q & ~redirect;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry that ID takes immediately is never stored.
    assign push = inflight_q & ~redirect & ~(bypass & id_ready);
    assign pop  = rst_n & fifo_nonempty & id_ready & ~redirect;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;

    // Redirect squashes the head so no stale instruction is offered.
    assign id_valid  = rst_n & ~redirect & (fifo_nonempty | bypass);
    assign id_inst   = bypass ? imem_rdata : inst_mem_q[rd_ptr_q];
    assign id_pc     = bypass ? req_pc_q   : pc_mem_q[rd_ptr_q];
    assign id_npc    = id_pc + 32'd4;
    assign occupancy = rst_n ? count_q : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                inflight_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Address of the request whose data arrives next cycle.
    always_ff @(posedge clk) begin
        req_pc_q <= fetch_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_queue
//
// Directed bench for if_prefetch_queue (DEPTH=4, RESET_PC=0, default build).
// The instruction memory returns the word address of each request, so every
// head entry must satisfy inst == pc >> 2.
// ---------------------------------------------------------------------------
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_npc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_npc      (id_npc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM model: data = word address, one cycle after request.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= {2'b00, imem_addr[31:2]};
    end

    typedef struct {
        logic        rst_n;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                                input logic rdy, input logic e_req, input logic [31:0] e_addr,
                                input logic e_val, input logic [31:0] e_pc, input logic [2:0] e_occ);
        vec_t v;
        v.rst_n = r;  v.redir = rd; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check mid-cycle.
    task automatic cyc(input string tag, input logic r, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic e_req, input logic [31:0] e_addr,
                       input logic e_val, input logic [31:0] e_pc, input logic [2:0] e_occ);
        @(posedge clk);
        #1;
        rst_n       = r;
        redirect    = rd;
        redirect_pc = rpc;
        id_ready    = rdy;
        #3;
        chk($sformatf("%s req", tag), {31'b0, imem_req}, {31'b0, e_req});
        if (e_req) chk($sformatf("%s addr", tag), imem_addr, e_addr);
        chk($sformatf("%s valid", tag), {31'b0, id_valid}, {31'b0, e_val});
        if (e_val) begin
            chk($sformatf("%s pc", tag), id_pc, e_pc);
            chk($sformatf("%s npc", tag), id_npc, e_pc + 32'd4);
            chk($sformatf("%s inst", tag), id_inst, {2'b00, e_pc[31:2]});
        end
        chk($sformatf("%s occ", tag), {29'b0, occupancy}, {29'b0, e_occ});
    endtask

    initial begin
        // Reset, fill with id_ready=0, then start streaming.
        tbl[0]  = mk(0, 0, 0, 0, 0, 32'h00, 0, 32'h00, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 32'h00, 0, 32'h00, 0);
        tbl[2]  = mk(1, 0, 0, 0, 1, 32'h00, 0, 32'h00, 0);
        tbl[3]  = mk(1, 0, 0, 0, 1, 32'h04, 0, 32'h00, 0);
        tbl[4]  = mk(1, 0, 0, 0, 1, 32'h08, 1, 32'h00, 1);
        tbl[5]  = mk(1, 0, 0, 0, 1, 32'h0C, 1, 32'h00, 2);
        tbl[6]  = mk(1, 0, 0, 0, 0, 32'h10, 1, 32'h00, 3);
        tbl[7]  = mk(1, 0, 0, 0, 0, 32'h10, 1, 32'h00, 4);
        tbl[8]  = mk(1, 0, 0, 0, 0, 32'h10, 1, 32'h00, 4);
        tbl[9]  = mk(1, 0, 0, 1, 0, 32'h10, 1, 32'h00, 4);
        tbl[10] = mk(1, 0, 0, 1, 1, 32'h10, 1, 32'h04, 3);
        tbl[11] = mk(1, 0, 0, 1, 1, 32'h14, 1, 32'h08, 2);
        tbl[12] = mk(1, 0, 0, 1, 1, 32'h18, 1, 32'h0C, 2);
        tbl[13] = mk(1, 0, 0, 1, 1, 32'h1C, 1, 32'h10, 2);

        for (int i = 0; i < 14; i++) begin
            cyc($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].redir, tbl[i].rpc, tbl[i].rdy,
                tbl[i].e_req, tbl[i].e_addr, tbl[i].e_val, tbl[i].e_pc, tbl[i].e_occ);
        end

        // Continuous streaming: one new PC every cycle, no gaps or repeats.
        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("stream%0d", i), 1, 0, 0, 1,
                1, 32'h14 + 32'(4 * i) + 32'h0C, 1, 32'h14 + 32'(4 * i), 2);
        end

        // Stall one cycle so the credit window is full with a response in flight.
        cyc("stall",   1, 0, 32'h0,   0, 1, 32'h60,  1, 32'h54,  2);
        cyc("redirT",  1, 1, 32'h103, 1, 0, 32'h0,   0, 32'h0,   3);
        cyc("redirT1", 1, 0, 32'h0,   1, 1, 32'h100, 0, 32'h0,   0);
        cyc("redirT2", 1, 0, 32'h0,   1, 1, 32'h104, 0, 32'h0,   0);
        cyc("redirT3", 1, 0, 32'h0,   1, 1, 32'h108, 1, 32'h100, 1);

        // Redirect together with a would-be pop while two entries are queued.
        cyc("hold",    1, 0, 32'h0,   0, 1, 32'h10C, 1, 32'h104, 1);
        cyc("rpopT",   1, 1, 32'h200, 1, 0, 32'h0,   0, 32'h0,   2);
        cyc("rpopT1",  1, 0, 32'h0,   1, 1, 32'h200, 0, 32'h0,   0);
        cyc("rpopT2",  1, 0, 32'h0,   1, 1, 32'h204, 0, 32'h0,   0);
        cyc("rpopT3",  1, 0, 32'h0,   1, 1, 32'h208, 1, 32'h200, 1);

        // Fetch PC wrap through the top of the address space.
        cyc("wrapT",   1, 1, 32'hFFFF_FFF8, 1, 0, 32'h0,         0, 32'h0,         1);
        cyc("wrapT1",  1, 0, 32'h0,         1, 1, 32'hFFFF_FFF8, 0, 32'h0,         0);
        cyc("wrapT2",  1, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0,         0);
        cyc("wrapT3",  1, 0, 32'h0,         1, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8, 1);
        cyc("wrapT4",  1, 0, 32'h0,         1, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC, 1);
        cyc("wrapT5",  1, 0, 32'h0,         1, 1, 32'h0000_0008, 1, 32'h0000_0000, 1);

        // Reset mid-stream with a response in flight.
        cyc("rstA",    0, 0, 32'h0, 1, 0, 32'h0,  0, 32'h0, 0);
        cyc("rstB",    1, 0, 32'h0, 1, 1, 32'h0,  0, 32'h0, 0);
        cyc("rstC",    1, 0, 32'h0, 1, 1, 32'h4,  0, 32'h0, 0);
        cyc("rstD",    1, 0, 32'h0, 1, 1, 32'h8,  1, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
